// File: rtl/lc3b_mem_seq.sv
// LC-3b memory access sequencer: loads MAR from the trap vector or the
// address adder, checks word alignment, runs one memory cycle with a bounded
// wait on R, and reports completion with an error flag.
module lc3b_mem_seq #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_trap,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [15:0] mar_q,
  output logic        marmux_sel,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        mem_en,
  output logic [1:0]  mem_we,
  input  logic        mem_r,
  output logic        resp_valid,
  output logic        resp_err
);

  typedef enum logic [2:0] {IDLE, LDMAR, CHECK, ACCESS, DONE} state_t;

  // Last wait-counter value before the access is declared timed out.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic             trap_q, write_q, byte_q;
  logic             err_q, err_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // State, error flag, wait counter and the latched request fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      err_q   <= 1'b0;
      cnt     <= '0;
      trap_q  <= 1'b0;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req_valid) begin
        // A trap fetch is always a word load, whatever the other fields say.
        trap_q  <= req_trap;
        write_q <= req_write & ~req_trap;
        byte_q  <= req_byte & ~req_trap;
      end
    end
  end

  // Next-state logic and Moore/Mealy strobes for the datapath.
  always_comb begin
    state_nxt  = state;
    err_nxt    = err_q;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    ld_mar     = 1'b0;
    ld_mdr     = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 2'b00;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    // Mux select stays put from LDMAR until the sequencer is idle again.
    marmux_sel = trap_q & (state != IDLE);
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = LDMAR;
      end
      LDMAR: begin
        ld_mar    = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        if (!byte_q && mar_q[0]) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt   = '0;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_en = 1'b1;
        if (write_q) mem_we = !byte_q ? 2'b11 : (mar_q[0] ? 2'b10 : 2'b01);
        // Ready beats a coincident timeout.
        if (mem_r) begin
          ld_mdr    = ~write_q;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        err_nxt    = 1'b0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lc3b_mem_seq.sv
// Scoreboard bench for lc3b_mem_seq: a request issuer pushes the expected
// outcome computed from the access rules, a negedge monitor collects what the
// DUT did per transaction and compares on resp_valid.
module tb_lc3b_mem_seq;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_trap = 1'b0, req_write = 1'b0, req_byte = 1'b0;
  logic        req_ready;
  logic [15:0] mar_q;
  logic        marmux_sel, ld_mar, ld_mdr, mem_en, resp_valid, resp_err;
  logic [1:0]  mem_we;
  logic        mem_r = 1'b0;

  lc3b_mem_seq #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_trap(req_trap), .req_write(req_write), .req_byte(req_byte),
    .mar_q(mar_q), .marmux_sel(marmux_sel), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mem_en(mem_en), .mem_we(mem_we), .mem_r(mem_r),
    .resp_valid(resp_valid), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int err; int lat; int en; int we; int mdr; int mux;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0, errors = 0;
  int          delay = 0;
  logic [15:0] tv = 16'h0, adder = 16'h0;
  bit          sb_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected outcome of one access, from the rules stated for the sequencer.
  function automatic exp_t model(bit trap, bit write, bit byt,
                                 logic [15:0] tvv, logic [15:0] ad, int d);
    exp_t e;
    bit w = trap ? 1'b0 : write;
    bit b = trap ? 1'b0 : byt;
    logic [15:0] a = trap ? tvv : ad;
    e.mux = trap; e.mdr = 0; e.err = 0;
    e.we  = !w ? 0 : (!b ? 3 : (a[0] ? 2 : 1));
    if (!b && a[0]) begin
      e.err = 1; e.en = 0; e.lat = 3; e.we = 0;
    end else if (d < TIMEOUT) begin
      e.en = d + 1; e.lat = 4 + d; e.mdr = w ? 0 : 1;
    end else begin
      e.en = TIMEOUT; e.lat = 3 + TIMEOUT; e.err = 1;
    end
    return e;
  endfunction

  // MAR register model: loads from the selected mux input on ld_mar.
  initial begin
    mar_q = 16'h0;
    forever begin
      @(negedge clk);
      if (ld_mar === 1'b1) mar_q = marmux_sel ? tv : adder;
    end
  end

  // Memory model: R rises after 'delay' wait cycles; random noise when idle.
  initial begin
    int acc;
    acc = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_en === 1'b1) begin
        mem_r = (acc == delay);
        acc++;
      end else begin
        mem_r = 1'($urandom_range(0, 1));
        acc = 0;
      end
    end
  end

  // Monitor: per-transaction observation, compared against the scoreboard.
  initial begin
    int t, nld, nen, nmdr, we, mux;
    bit busy;
    exp_t e;
    busy = 0; t = 0; nld = 0; nen = 0; nmdr = 0; we = 0; mux = 0;
    forever begin
      @(negedge clk);
      if (!sb_on || reset) busy = 0;
      else if (busy) begin
        t++;
        if (ld_mar) begin nld++; mux = int'(marmux_sel); end
        if (mem_en) begin nen++; we = int'(mem_we); end
        if (ld_mdr) nmdr++;
        if (resp_valid) begin
          busy = 0;
          chk("sb_has_entry", sbq.size() > 0, 1);
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("resp_err", resp_err, e.err);
            chk("latency", t, e.lat);
            chk("mem_en_cycles", nen, e.en);
            chk("mem_we", we, e.we);
            chk("ld_mdr_pulses", nmdr, e.mdr);
            chk("ld_mar_pulses", nld, 1);
            chk("marmux_sel", mux, e.mux);
          end
        end
      end else begin
        chk("resp_valid_idle", resp_valid, 0);
        if (req_valid && req_ready) begin
          busy = 1; t = 0; nld = 0; nen = 0; nmdr = 0; we = 0; mux = 0;
        end
      end
    end
  end

  task automatic issue(input bit trap, input bit write, input bit byt,
                       input logic [15:0] tvv, input logic [15:0] ad, input int d);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
    sbq.push_back(model(trap, write, byt, tvv, ad, d));
    delay = d; tv = tvv; adder = ad;
    req_trap = trap; req_write = write; req_byte = byt; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    // Junk on the request fields after acceptance must not matter.
    req_trap = 1'($urandom); req_write = 1'($urandom); req_byte = 1'($urandom);
    n = 0;
    while (sbq.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (sbq.size() != 0) begin
      chk("completion_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  initial begin
    int n;
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_outs", {marmux_sel, ld_mar, ld_mdr, mem_en, mem_we, resp_valid, resp_err}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset in the middle of ACCESS abandons the transaction.
    delay = 1000; adder = 16'h2000;
    req_trap = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (mem_en !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("mid_rst_in_access", mem_en, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_outs", {marmux_sel, ld_mar, ld_mdr, mem_en, mem_we, resp_valid, resp_err}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_rst_no_resp", resp_valid, 0);
    end
    sb_on = 1;

    // Directed cases.
    issue(0, 0, 0, 16'h0000, 16'h3000, 1);   // word load, R on 2nd ACCESS cycle
    issue(1, 1, 0, 16'h0046, 16'h1235, 0);   // trap fetch, write ignored
    issue(0, 1, 1, 16'h0000, 16'h4001, 0);   // byte store odd  -> 10
    issue(0, 1, 1, 16'h0000, 16'h4000, 2);   // byte store even -> 01
    issue(0, 1, 0, 16'h0000, 16'h4000, 0);   // word store      -> 11
    issue(0, 0, 0, 16'h0000, 16'h4001, 0);   // unaligned word load
    issue(0, 0, 0, 16'h0000, 16'h3000, 100); // timeout
    issue(0, 0, 0, 16'h0000, 16'h3000, TIMEOUT - 1); // R on last cycle wins
    issue(0, 1, 0, 16'h0000, 16'h5003, 0);   // unaligned word store
    issue(1, 0, 1, 16'h0047, 16'h4000, 0);   // odd trap vector -> error

    // Randomized traffic.
    for (int i = 0; i < 60; i++)
      issue(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
            16'($urandom), 16'($urandom), int'($urandom_range(0, 20)));

    chk("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lc3b_mem_seq.md
Name: lc3b_mem_seq

Overview:
- Sequences one LC-3b memory access at a time.
- Drives the MAR source select, the MAR/MDR load strobes and the memory enable/write lanes, then waits for the memory ready (R).
- Accepts requests from the control unit. Source is either the trap vector (MAR mux input 0) or the address adder (MAR mux input 1).
- Checks word alignment and bounds the wait for R with a timeout. Sits between the microsequencer and the MAR/MDR/memory datapath.

Parameters:
- TIMEOUT, 16, max cycles in ACCESS waiting for mem_r before an error (1..255).
- CNT_W, 8, width of the wait counter; must hold TIMEOUT.

Ports:
- clk, input, 1, system clock; everything is sampled on the rising edge.
- reset, input, 1, synchronous, active-high.
- req_valid, input, 1, access request.
- req_ready, output, 1, sequencer can accept a request.
- req_trap, input, 1, 1 = source is the trap vector (mux input 0); 0 = source is the address adder (mux input 1).
- req_write, input, 1, 1 = store, 0 = load. Ignored (forced to 0) when req_trap=1.
- req_byte, input, 1, 1 = byte access, 0 = word access. Ignored (forced to 0) when req_trap=1.
- mar_q, input, 16, current MAR contents (fed back from the MAR register).
- marmux_sel, output, 1, MAR mux select; 1 picks input 0 (trap vector).
- ld_mar, output, 1, MAR load strobe.
- ld_mdr, output, 1, MDR load strobe (load completion).
- mem_en, output, 1, memory enable.
- mem_we, output, 2, write lane enables {hi, lo}.
- mem_r, input, 1, memory ready.
- resp_valid, output, 1, one-cycle completion pulse.
- resp_err, output, 1, qualifies resp_valid: unaligned access or timeout.

Behaviour:
- Reset value of every output is 0, except req_ready=1 in IDLE after reset. State goes to IDLE, the counter clears and the latched request clears. Reset mid-access abandons it: no resp_valid, mem_en drops on the next edge.
- States: IDLE, LDMAR, CHECK, ACCESS, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch trap/write/byte (write and byte forced to 0 if trap) and go to LDMAR.
- LDMAR:
  - ld_mar=1 and marmux_sel=latched trap, for exactly one cycle.
  - Go to CHECK.
  - marmux_sel holds the latched value from LDMAR until back in IDLE; it is 0 in IDLE.
- CHECK:
  - mar_q is now valid.
  - If word access and mar_q[0]=1: set the error flag and go to DONE with no memory cycle.
  - Otherwise go to ACCESS and clear the counter.
- ACCESS:
  - mem_en=1.
  - mem_we: load gives 2'b00; word store gives 2'b11; byte store gives 2'b10 if mar_q[0]=1, else 2'b01.
  - Counter increments each cycle mem_r=0.
  - If mem_r=1: for a load, pulse ld_mdr=1 in that same cycle. Go to DONE with no error.
  - Else if counter == TIMEOUT-1: set the error flag and go to DONE (mem_en deasserts).
  - mem_r and timeout in the same cycle: mem_r wins, no error.
- DONE:
  - resp_valid=1 for one cycle; resp_err=error flag.
  - Go to IDLE; the error flag clears.
- Latency, load/store with mem_r high on the first ACCESS cycle: acceptance edge to resp_valid = 4 cycles (LDMAR, CHECK, ACCESS, DONE).
- Unaligned error: 3 cycles.
- Back-to-back: a new request is accepted the cycle after DONE, when IDLE is re-entered.
- mem_r outside ACCESS is ignored.
- req_valid outside IDLE is ignored; the requester must hold it until req_ready.

Test Plan:
- Reset asserted mid-ACCESS (mem_en=1) -> next cycle all outputs 0, req_ready=1, no resp_valid.
- Word load, req_trap=0, mar_q=16'h3000, mem_r high on 2nd ACCESS cycle:
  - ld_mar pulse with marmux_sel=0.
  - mem_en for 2 cycles, mem_we=00.
  - ld_mdr pulse with mem_r.
  - resp_valid=1, resp_err=0.
- Trap fetch, req_trap=1, req_write=1, mar_q=16'h0046, mem_r immediate -> marmux_sel=1 during LDMAR; treated as a word load (mem_we=00); resp_err=0 at cycle 4.
- Byte store at mar_q=16'h4001 -> mem_we=2'b10. At 16'h4000 -> 2'b01. Word store at 16'h4000 -> 2'b11. ld_mdr stays 0 throughout.
- Word load at mar_q=16'h4001 -> mem_en never asserts; resp_valid=1, resp_err=1 three cycles after acceptance.
- mem_r held 0, TIMEOUT=16 -> mem_en high exactly 16 cycles, then resp_err=1. Repeat with mem_r rising on the 16th cycle -> resp_err=0, ld_mdr=1.
